// File: rtl/md_i2s_out.sv
// Philips I2S serializer for the mixed stereo output: latches A_L/A_R once per
// 64-slot frame and shifts them out MSB first, one BCLK after each LRCK edge.
module md_i2s_out #(
  parameter int BCLK_DIV = 9
) (
  input  logic        MCLK,
  input  logic        ext_reset,
  input  logic [15:0] A_L,
  input  logic [15:0] A_R,
  input  logic        mute,
  input  logic [1:0]  atten,
  output logic        I2S_BCLK,
  output logic        I2S_LRCK,
  output logic        I2S_DATA,
  output logic        frame_stb
);
  localparam int DW = $clog2(BCLK_DIV);

  // No handshake: the upstream is free-running; A_L, A_R, mute and atten are
  // sampled only on the frame-end falling event and ignored at all other times.
  logic [DW-1:0] div_cnt;
  logic [5:0]    slot;
  logic [5:0]    slot_nxt;
  logic [15:0]   hold_l;
  logic [15:0]   hold_r;
  logic [15:0]   lat_l;
  logic [15:0]   lat_r;
  logic [3:0]    bit_l;
  logic [3:0]    bit_r;
  logic          tc;
  logic          fall_evt;
  logic          frame_end;
  logic          data_nxt;

  assign tc        = (div_cnt == DW'(BCLK_DIV - 1));
  assign fall_evt  = tc && I2S_BCLK;
  assign frame_end = fall_evt && (slot == 6'd63);
  assign slot_nxt  = slot + 6'd1;
  assign bit_l     = 4'(6'd16 - slot_nxt);
  assign bit_r     = 4'(6'd48 - slot_nxt);
  assign lat_l     = mute ? 16'h0000 : 16'($signed(A_L) >>> atten);
  assign lat_r     = mute ? 16'h0000 : 16'($signed(A_R) >>> atten);

  // Bit for the slot being entered; slots 0 and 32 are the one-bit delay slots.
  always_comb begin
    data_nxt = 1'b0;
    if (slot_nxt >= 6'd1 && slot_nxt <= 6'd16) begin
      data_nxt = hold_l[bit_l];
    end else if (slot_nxt >= 6'd33 && slot_nxt <= 6'd48) begin
      data_nxt = hold_r[bit_r];
    end
  end

  always_ff @(posedge MCLK) begin
    if (ext_reset) begin
      div_cnt   <= '0;
      slot      <= 6'd0;
      hold_l    <= 16'h0000;
      hold_r    <= 16'h0000;
      I2S_BCLK  <= 1'b0;
      I2S_LRCK  <= 1'b0;
      I2S_DATA  <= 1'b0;
      frame_stb <= 1'b0;
    end else begin
      frame_stb <= 1'b0;
      if (tc) begin
        div_cnt  <= '0;
        I2S_BCLK <= ~I2S_BCLK;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (fall_evt) begin
        slot     <= slot_nxt;
        I2S_LRCK <= slot_nxt[5];
        I2S_DATA <= data_nxt;
      end
      // The outgoing frame is complete here, so the hold regs can be reloaded.
      if (frame_end) begin
        hold_l    <= lat_l;
        hold_r    <= lat_r;
        frame_stb <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_md_i2s_out.sv
// Bench for md_i2s_out with BCLK_DIV=2 (frame = 256 MCLK): frames are captured at
// BCLK rises and compared against an expected-frame queue.
module tb_md_i2s_out;
  localparam logic [63:0] LR_EXP = {32'hFFFF_FFFF, 32'h0000_0000};

  logic        MCLK = 1'b0;
  logic        ext_reset = 1'b1;
  logic [15:0] A_L = 16'h0000;
  logic [15:0] A_R = 16'h0000;
  logic        mute = 1'b0;
  logic [1:0]  atten = 2'd0;
  logic        I2S_BCLK;
  logic        I2S_LRCK;
  logic        I2S_DATA;
  logic        frame_stb;

  int passed = 0;
  int total = 0;
  logic [63:0] exp_q[$];

  md_i2s_out #(.BCLK_DIV(2)) dut (
    .MCLK      (MCLK),
    .ext_reset (ext_reset),
    .A_L       (A_L),
    .A_R       (A_R),
    .mute      (mute),
    .atten     (atten),
    .I2S_BCLK  (I2S_BCLK),
    .I2S_LRCK  (I2S_LRCK),
    .I2S_DATA  (I2S_DATA),
    .frame_stb (frame_stb)
  );

  always #5 MCLK = ~MCLK;

  // Expected serial frame: bit n is the DATA value during slot n.
  function automatic logic [63:0] frame_bits(input logic [15:0] l, input logic [15:0] r);
    logic [63:0] f;
    f = '0;
    for (int i = 0; i < 16; i++) begin
      f[1 + i]  = l[15 - i];
      f[33 + i] = r[15 - i];
    end
    return f;
  endfunction

  function automatic logic [15:0] sra(input logic [15:0] v, input logic [1:0] s);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < int'(s); i++) r = {r[15], r[15:1]};
    return r;
  endfunction

  // Records DATA/LRCK at the 64 BCLK rises of one frame; optionally waits for the
  // strobe first and applies new inputs at the rise of poke_slot.
  task automatic capture_frame(input bit wait_stb, input int poke_slot,
                               input logic [15:0] pl, input logic [15:0] pr,
                               input logic pm, input logic [1:0] pa,
                               output logic [63:0] d, output logic [63:0] lr,
                               output bit ok);
    int guard;
    int n;
    logic prev_b;
    ok = 1'b1;
    d = '0;
    lr = '0;
    if (wait_stb) begin
      guard = 0;
      do begin
        @(negedge MCLK);
        guard++;
      end while (frame_stb !== 1'b1 && guard < 1000);
      if (frame_stb !== 1'b1) ok = 1'b0;
    end
    prev_b = I2S_BCLK;
    n = 0;
    guard = 0;
    while (n < 64 && guard < 1000) begin
      @(negedge MCLK);
      guard++;
      if (I2S_BCLK === 1'b1 && prev_b === 1'b0) begin
        d[n] = I2S_DATA;
        lr[n] = I2S_LRCK;
        if (n == poke_slot) begin
          A_L = pl;
          A_R = pr;
          mute = pm;
          atten = pa;
        end
        n++;
      end
      prev_b = I2S_BCLK;
    end
    if (n < 64) ok = 1'b0;
  endtask

  task automatic test_reset(input int len, input bit stop_early);
    int rise_c, fall_c, lr_c, stb_c;
    logic prev_b;
    bit data_seen;
    ext_reset = 1'b1;
    for (int i = 0; i < len; i++) begin
      @(negedge MCLK);
      total++;
      if ({I2S_BCLK, I2S_LRCK, I2S_DATA, frame_stb} !== 4'b0000)
        $display("FAIL reset_outputs: got %b want 0000",
                 {I2S_BCLK, I2S_LRCK, I2S_DATA, frame_stb});
      else passed++;
    end
    ext_reset = 1'b0;
    rise_c = -1; fall_c = -1; lr_c = -1; stb_c = -1;
    prev_b = 1'b0;
    data_seen = 1'b0;
    for (int c = 1; c <= 255; c++) begin
      @(negedge MCLK);
      if (I2S_BCLK === 1'b1 && prev_b === 1'b0 && rise_c < 0) rise_c = c;
      if (I2S_BCLK === 1'b0 && prev_b === 1'b1 && fall_c < 0) fall_c = c;
      if (I2S_LRCK === 1'b1 && lr_c < 0) lr_c = c;
      if (frame_stb !== 1'b0 && stb_c < 0) stb_c = c;
      if (I2S_DATA !== 1'b0) data_seen = 1'b1;
      prev_b = I2S_BCLK;
    end
    total++;
    if (rise_c != 2) $display("FAIL first_bclk_rise: got %0d want 2", rise_c); else passed++;
    total++;
    if (fall_c != 4) $display("FAIL first_bclk_fall: got %0d want 4", fall_c); else passed++;
    total++;
    if (lr_c != 128) $display("FAIL first_lrck_high: got %0d want 128", lr_c); else passed++;
    total++;
    if (stb_c != -1) $display("FAIL early_stb: got cycle %0d want none before 256", stb_c); else passed++;
    total++;
    if (data_seen) $display("FAIL first_frame_zero: got nonzero DATA want all 0"); else passed++;
    if (!stop_early) begin
      @(negedge MCLK);
      total++;
      if (frame_stb !== 1'b1) $display("FAIL stb_at_256: got %b want 1", frame_stb); else passed++;
      @(negedge MCLK);
      total++;
      if (frame_stb !== 1'b0) $display("FAIL stb_width: got %b want 0 at 257", frame_stb); else passed++;
    end
  endtask

  task automatic test_data();
    logic [63:0] d, lr, e;
    bit ok;
    capture_frame(1'b0, -1, A_L, A_R, mute, atten, d, lr, ok);
    e = exp_q.pop_front();
    total++;
    if (!ok) $display("FAIL data_timeout: got no frame want frame"); else passed++;
    total++;
    if (d !== e) $display("FAIL data_bits: got %h want %h", d, e); else passed++;
    total++;
    if (lr !== LR_EXP) $display("FAIL data_lrck: got %h want %h", lr, LR_EXP); else passed++;
  endtask

  task automatic test_mute();
    logic [63:0] d, lr, e;
    bit ok;
    A_L = 16'h1357; A_R = 16'h2468; mute = 1'b0; atten = 2'd0;
    exp_q.push_back(frame_bits(16'h1357, 16'h2468));
    capture_frame(1'b1, 20, 16'h1357, 16'h2468, 1'b1, 2'd0, d, lr, ok);
    exp_q.push_back(64'h0);
    e = exp_q.pop_front();
    total++;
    if (!ok || d !== e) $display("FAIL mute_current_frame: got %h ok=%0d want %h", d, ok, e); else passed++;
    capture_frame(1'b1, -1, A_L, A_R, mute, atten, d, lr, ok);
    e = exp_q.pop_front();
    total++;
    if (!ok) $display("FAIL mute_stb: got no strobe want strobe"); else passed++;
    total++;
    if (d !== e) $display("FAIL mute_frame: got %h want %h", d, e); else passed++;
    total++;
    if (lr !== LR_EXP) $display("FAIL mute_lrck: got %h want %h", lr, LR_EXP); else passed++;
  endtask

  task automatic test_atten();
    logic [63:0] d, lr, e;
    bit ok;
    mute = 1'b0; atten = 2'd2; A_L = 16'h8000; A_R = 16'h0007;
    exp_q.push_back(frame_bits(16'hE000, 16'h0001));
    capture_frame(1'b1, -1, A_L, A_R, mute, atten, d, lr, ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || d !== e) $display("FAIL atten_frame: got %h ok=%0d want %h", d, ok, e); else passed++;
  endtask

  task automatic test_stability();
    logic [63:0] d, lr, e;
    bit ok;
    atten = 2'd0; A_L = 16'h1234; A_R = 16'h00AA;
    exp_q.push_back(frame_bits(16'h1234, 16'h00AA));
    exp_q.push_back(frame_bits(16'hFFFF, 16'h00AA));
    capture_frame(1'b1, 5, 16'hFFFF, 16'h00AA, 1'b0, 2'd0, d, lr, ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || d !== e) $display("FAIL stable_frame: got %h ok=%0d want %h", d, ok, e); else passed++;
    capture_frame(1'b1, -1, A_L, A_R, mute, atten, d, lr, ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || d !== e) $display("FAIL stable_next_frame: got %h ok=%0d want %h", d, ok, e); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [63:0] d, lr, e;
    bit ok;
    for (int k = 0; k < 4; k++) begin
      A_L = 16'($urandom_range(0, 65535));
      A_R = 16'($urandom_range(0, 65535));
      atten = 2'($urandom_range(0, 3));
      mute = ($urandom_range(0, 3) == 0);
      exp_q.push_back(mute ? 64'h0 : frame_bits(sra(A_L, atten), sra(A_R, atten)));
      capture_frame(1'b1, -1, A_L, A_R, mute, atten, d, lr, ok);
      e = exp_q.pop_front();
      total++;
      if (!ok || d !== e) $display("FAIL rand_frame_%0d: got %h ok=%0d want %h", k, d, ok, e); else passed++;
    end
    mute = 1'b0;
    atten = 2'd0;
  endtask

  task automatic test_mid_reset();
    logic [63:0] d, lr, e;
    bit ok;
    int guard, n;
    logic prev_b;
    A_L = 16'hFFFF; A_R = 16'hFFFF;
    guard = 0;
    do begin
      @(negedge MCLK);
      guard++;
    end while (frame_stb !== 1'b1 && guard < 1000);
    prev_b = I2S_BCLK;
    n = 0;
    while (n < 40 && guard < 2000) begin
      @(negedge MCLK);
      guard++;
      if (I2S_BCLK === 1'b0 && prev_b === 1'b1) n++;
      prev_b = I2S_BCLK;
    end
    total++;
    if (n != 40 || I2S_LRCK !== 1'b1) $display("FAIL midreset_reach_slot40: got falls=%0d lrck=%b want 40/1", n, I2S_LRCK); else passed++;
    test_reset(1, 1'b0);
    exp_q.push_back(frame_bits(16'hFFFF, 16'hFFFF));
    capture_frame(1'b0, -1, A_L, A_R, mute, atten, d, lr, ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || d !== e) $display("FAIL midreset_next_frame: got %h ok=%0d want %h", d, ok, e); else passed++;
  endtask

  task automatic test_latch_reset();
    logic [63:0] d, lr, e;
    bit ok, data_seen;
    int stb_c;
    A_L = 16'hA5A5; A_R = 16'h5A5A;
    test_reset(1, 1'b1);
    ext_reset = 1'b1;
    @(negedge MCLK);
    total++;
    if ({I2S_BCLK, I2S_LRCK, I2S_DATA, frame_stb} !== 4'b0000)
      $display("FAIL latch_reset_outputs: got %b want 0000", {I2S_BCLK, I2S_LRCK, I2S_DATA, frame_stb});
    else passed++;
    ext_reset = 1'b0;
    stb_c = -1;
    data_seen = 1'b0;
    for (int c = 1; c <= 256; c++) begin
      @(negedge MCLK);
      if (frame_stb === 1'b1 && stb_c < 0) stb_c = c;
      if (I2S_DATA !== 1'b0) data_seen = 1'b1;
    end
    total++;
    if (data_seen) $display("FAIL latch_reset_hold: got nonzero DATA want all 0"); else passed++;
    total++;
    if (stb_c != 256) $display("FAIL latch_reset_stb: got %0d want 256", stb_c); else passed++;
    exp_q.push_back(frame_bits(16'hA5A5, 16'h5A5A));
    capture_frame(1'b0, -1, A_L, A_R, mute, atten, d, lr, ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || d !== e) $display("FAIL latch_reset_frame: got %h ok=%0d want %h", d, ok, e); else passed++;
  endtask

  initial begin
    A_L = 16'h8001;
    A_R = 16'h7FFE;
    exp_q.push_back(frame_bits(16'h8001, 16'h7FFE));
    test_reset(3, 1'b0);
    test_data();
    test_mute();
    test_atten();
    test_stability();
    test_back_to_back();
    test_mid_reset();
    test_latch_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
